// File: rtl/des_key_schedule.sv
// des_key_schedule
//   Produces the sixteen 48-bit DES round subkeys one at a time, in encrypt
//   (K1..K16) or decrypt (K16..K1) order. C/D halves are kept in registers and
//   rotated in place on every accepted advance; no subkey table is stored.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high; clears all state and outputs
//   key[63:0]     DES key, DES bit 1 = key[63]; byte LSBs are parity bits
//   decrypt       sampled on load: 0 = encrypt order, 1 = decrypt order
//   load          strobe: latch PC-1(key) into C/D, clear the round count
//   advance       strobe: rotate C/D and issue the next subkey
//   subkey[47:0]  PC-2(C,D) of the issued round, DES bit 1 = subkey[47]
//   subkey_valid  one-cycle pulse qualifying subkey/subkey_round
//   subkey_round  sequence position 0..15 of the issued subkey
//   done          high once 16 subkeys were issued since the last load
//   overrun       sticky: advance seen after done or before any load
//   parity_err    sticky: a loaded key had an even-parity byte
//                 (only when PARITY_CHECK != 0, otherwise stays 0)
//
// Handshake: load and advance are single-cycle strobes with no back-pressure.
// An accepted advance in cycle t yields subkey_valid in cycle t+1; one
// advance per cycle is sustainable. load has priority over advance.
module des_key_schedule #(
  parameter int PARITY_CHECK = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        load,
  input  logic        advance,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  subkey_round,
  output logic        done,
  output logic        overrun,
  output logic        parity_err
);

  // Permuted choice tables in DES 1-based bit numbering.
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TBL[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd_in);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd_in[56-PC2_TBL[i]];
    return r;
  endfunction

  logic [27:0] c, d;
  logic [27:0] c_next, d_next;
  logic        mode;      // 1 = decrypt order
  logic [3:0]  count;
  logic        loaded;
  logic [1:0]  rot_amt;
  logic [55:0] key_pc1;
  logic        key_par_bad;
  logic        adv_ok;

  assign key_pc1 = pc1(key);
  assign adv_ok  = loaded && !done;

  // Decrypt uses right rotations with a zero first step, so round 0 sees the
  // unrotated C0/D0, which equals C16/D16 of the encrypt walk.
  always_comb begin
    rot_amt = 2'd2;
    if (mode) begin
      if (count == 4'd0)
        rot_amt = 2'd0;
      else if (count == 4'd1 || count == 4'd8 || count == 4'd15)
        rot_amt = 2'd1;
    end else if (count == 4'd0 || count == 4'd1 || count == 4'd8 || count == 4'd15) begin
      rot_amt = 2'd1;
    end
  end

  // DES bit 1 is the MSB, so a DES left rotation moves bits toward the MSB.
  always_comb begin
    c_next = c;
    d_next = d;
    case ({mode, rot_amt})
      3'b0_01: begin c_next = {c[26:0], c[27]};    d_next = {d[26:0], d[27]};    end
      3'b0_10: begin c_next = {c[25:0], c[27:26]}; d_next = {d[25:0], d[27:26]}; end
      3'b1_01: begin c_next = {c[0], c[27:1]};     d_next = {d[0], d[27:1]};     end
      3'b1_10: begin c_next = {c[1:0], c[27:2]};   d_next = {d[1:0], d[27:2]};   end
      default: begin c_next = c;                   d_next = d;                   end
    endcase
  end

  // A byte with an even number of ones violates DES odd parity.
  always_comb begin
    key_par_bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (!(^key[8*b +: 8])) key_par_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c            <= '0;
      d            <= '0;
      mode         <= 1'b0;
      count        <= '0;
      loaded       <= 1'b0;
      subkey       <= '0;
      subkey_round <= '0;
      subkey_valid <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
      parity_err   <= 1'b0;
    end else begin
      subkey_valid <= 1'b0;
      if (load) begin
        c      <= key_pc1[55:28];
        d      <= key_pc1[27:0];
        mode   <= decrypt;
        count  <= '0;
        done   <= 1'b0;
        loaded <= 1'b1;
        if (PARITY_CHECK != 0 && key_par_bad) parity_err <= 1'b1;
      end else if (advance) begin
        if (adv_ok) begin
          c            <= c_next;
          d            <= d_next;
          subkey       <= pc2({c_next, d_next});
          subkey_round <= count;
          subkey_valid <= 1'b1;
          count        <= count + 4'd1;
          if (count == 4'd15) done <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: two instances (parity check off/on)
// share stimulus; a scoreboard queue holds {round, subkey} expectations that
// a negedge monitor pops when subkey_valid pulses.
module tb_des_key_schedule;

  localparam int W = 52;

  logic        clk;
  logic        reset;
  logic [63:0] key;
  logic        decrypt;
  logic        load;
  logic        advance;

  logic [47:0] sk, sk_p;
  logic        sk_valid, sk_valid_p;
  logic [3:0]  sk_round, sk_round_p;
  logic        done, done_p;
  logic        overrun, overrun_p;
  logic        par_err, par_err_p;

  int checks;
  int failures;

  logic [W-1:0] exp_q[$];
  logic [47:0]  m_keys [16];
  logic [47:0]  got [16];
  logic         m_loaded, m_done, m_dec;
  int           m_count;

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;

  des_key_schedule u_dut (
    .clk(clk), .reset(reset), .key(key), .decrypt(decrypt), .load(load),
    .advance(advance), .subkey(sk), .subkey_valid(sk_valid),
    .subkey_round(sk_round), .done(done), .overrun(overrun),
    .parity_err(par_err)
  );

  des_key_schedule #(.PARITY_CHECK(1)) u_dut_p (
    .clk(clk), .reset(reset), .key(key), .decrypt(decrypt), .load(load),
    .advance(advance), .subkey(sk_p), .subkey_valid(sk_valid_p),
    .subkey_round(sk_round_p), .done(done_p), .overrun(overrun_p),
    .parity_err(par_err_p)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: each Ci/Di is C0/D0 rotated by the cumulative shift.
  function automatic logic des_bit(input logic [63:0] k, input int n);
    return k[64-n];
  endfunction

  task automatic build_model(input logic [63:0] k);
    int pc1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int pc2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int cum [16] = '{1,2,4,6,8,10,12,14,15,17,19,21,23,25,27,28};
    logic [27:0] c0, d0, cs, ds;
    logic [55:0] cd;
    logic [47:0] s;
    c0 = '0; d0 = '0;
    for (int i = 0; i < 28; i++) c0 = {c0[26:0], des_bit(k, pc1[i])};
    for (int i = 28; i < 56; i++) d0 = {d0[26:0], des_bit(k, pc1[i])};
    for (int r = 0; r < 16; r++) begin
      cs = (c0 << cum[r]) | (c0 >> (28 - cum[r]));
      ds = (d0 << cum[r]) | (d0 >> (28 - cum[r]));
      cd = {cs, ds};
      s = '0;
      for (int j = 0; j < 48; j++) s = {s[46:0], cd[56 - pc2[j]]};
      m_keys[r] = s;
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load = 1'b0;
    advance = 1'b0;
    m_loaded = 1'b0; m_done = 1'b0; m_count = 0; m_dec = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [63:0] k, input logic dec, input logic with_adv);
    key = k;
    decrypt = dec;
    load = 1'b1;
    advance = with_adv;
    build_model(k);
    m_loaded = 1'b1; m_done = 1'b0; m_count = 0; m_dec = dec;
    tick();
    load = 1'b0;
    advance = 1'b0;
    key = 64'($urandom()) << 32 | 64'($urandom());
    decrypt = 1'($urandom_range(0, 1));
  endtask

  task automatic do_advance();
    int idx;
    advance = 1'b1;
    if (m_loaded && !m_done) begin
      idx = m_dec ? 15 - m_count : m_count;
      exp_q.push_back({4'(m_count), m_keys[idx]});
      if (m_count == 15) m_done = 1'b1;
      m_count++;
    end
    tick();
    advance = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (sk_valid || sk_valid_p) begin
      if (exp_q.size() == 0) begin
        check("valid_without_expectation", {62'd0, sk_valid, sk_valid_p}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("valid", {62'd0, sk_valid, sk_valid_p}, 64'd3);
        check("subkey_round", {56'd0, sk_round, sk_round_p}, {56'd0, e[51:48], e[51:48]});
        check("subkey", {16'd0, sk}, {16'd0, e[47:0]});
        check("subkey_p", {16'd0, sk_p}, {16'd0, e[47:0]});
        check("done_with_valid", {63'd0, done}, {63'd0, e[51:48] == 4'd15});
        got[e[51:48]] = sk;
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    key = '0; decrypt = 1'b0; load = 1'b0; advance = 1'b0; reset = 1'b1;
    m_loaded = 1'b0; m_done = 1'b0; m_count = 0; m_dec = 1'b0;
    idle(2);
    do_reset();

    // reset state
    check("reset_subkey", {16'd0, sk}, 64'd0);
    check("reset_flags", {58'd0, sk_valid, done, overrun, par_err, par_err_p, 1'b0}, 64'd0);
    check("reset_round", {60'd0, sk_round}, 64'd0);

    // encrypt order, back-to-back
    do_load(KEY1, 1'b0, 1'b0);
    check("load_no_valid", {63'd0, sk_valid}, 64'd0);
    check("c0", {36'd0, u_dut.c}, {36'd0, 28'hF0CCAAF});
    check("d0", {36'd0, u_dut.d}, {36'd0, 28'h556678F});
    for (int i = 0; i < 16; i++) do_advance();
    idle(1);
    check("enc_done", {63'd0, done}, 64'd1);
    check("enc_k0", {16'd0, got[0]}, {16'd0, 48'h1B02EFFC7072});
    check("enc_k1", {16'd0, got[1]}, {16'd0, 48'h79AED9DBC9E5});
    check("enc_k15", {16'd0, got[15]}, {16'd0, 48'hCB3D8B0E17F5});
    check("enc_c_end", {36'd0, u_dut.c}, {36'd0, 28'hF0CCAAF});
    check("enc_d_end", {36'd0, u_dut.d}, {36'd0, 28'h556678F});

    // decrypt order
    do_load(KEY1, 1'b1, 1'b0);
    check("dec_load_done_clr", {63'd0, done}, 64'd0);
    for (int i = 0; i < 16; i++) do_advance();
    idle(1);
    check("dec_k0", {16'd0, got[0]}, {16'd0, 48'hCB3D8B0E17F5});
    check("dec_k15", {16'd0, got[15]}, {16'd0, 48'h1B02EFFC7072});
    check("dec_done", {63'd0, done}, 64'd1);
    check("no_overrun_yet", {63'd0, overrun}, 64'd0);

    // load and advance collide: load wins, nothing issued, no overrun
    do_load(KEY1, 1'b0, 1'b1);
    idle(1);
    check("collide_overrun", {63'd0, overrun}, 64'd0);
    check("collide_q_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 5; i++) do_advance();
    idle(1);
    check("mid_round", {60'd0, sk_round}, 64'd4);

    // restart mid-sequence with a new key
    do_load(KEY2, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) do_advance();
    idle(1);
    check("key2_done", {63'd0, done}, 64'd1);

    // gaps of 0..3 idle cycles, then a 17th advance
    do_load(KEY1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      do_advance();
      idle($urandom_range(0, 3));
    end
    idle(1);
    check("gap_k0", {16'd0, got[0]}, {16'd0, 48'h1B02EFFC7072});
    check("gap_k15", {16'd0, got[15]}, {16'd0, 48'hCB3D8B0E17F5});
    check("gap_overrun_before", {63'd0, overrun}, 64'd0);
    do_advance();
    idle(1);
    check("overrun_17th", {63'd0, overrun}, 64'd1);
    do_load(KEY1, 1'b1, 1'b0);
    check("overrun_sticky_load", {63'd0, overrun}, 64'd1);

    // reset after 7 rounds
    do_load(KEY2, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) do_advance();
    do_reset();
    check("rst_subkey", {16'd0, sk}, 64'd0);
    check("rst_round", {60'd0, sk_round}, 64'd0);
    check("rst_flags", {60'd0, sk_valid, done, overrun, par_err_p}, 64'd0);
    do_advance();
    idle(1);
    check("overrun_after_reset", {63'd0, overrun}, 64'd1);

    // parity checking
    do_load(KEY1, 1'b0, 1'b0);
    check("parity_good", {62'd0, par_err, par_err_p}, 64'd0);
    do_load(64'h0, 1'b0, 1'b0);
    check("parity_bad", {62'd0, par_err, par_err_p}, 64'd1);
    do_load(KEY1, 1'b0, 1'b0);
    check("parity_sticky", {62'd0, par_err, par_err_p}, 64'd1);
    do_reset();
    check("parity_reset", {63'd0, par_err_p}, 64'd0);

    idle(3);
    check("pending_expected", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Generates the sixteen 48-bit DES round subkeys, one per round, in encrypt or decrypt order.
- Sits directly downstream of the DES control unit. `load` is driven by the control unit's init_perm strobe; `advance` is driven by its round_op strobe.
- Feeds the round-function datapath, which consumes `subkey` when `subkey_valid` is high.
- Holds the C/D halves internally and rotates them in place. No 16-entry key table.

Parameters:
- PARITY_CHECK, 0, when 1 the odd parity of each key byte is checked at load time and reported on parity_err; when 0, parity_err is tied 0.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- key  input  64  DES key; DES bit 1 = key[63]; bits 8,16,...,64 are parity
- decrypt  input  1  sampled on load: 0 = encrypt order K1..K16, 1 = decrypt order K16..K1
- load  input  1  single-cycle strobe: latch PC-1(key) into C/D and clear the round count
- advance  input  1  single-cycle strobe: produce the next subkey
- subkey  output  48  PC-2(C,D) of the current round; DES bit 1 = subkey[47]
- subkey_valid  output  1  one-cycle pulse, subkey and subkey_round are valid
- subkey_round  output  4  index 0..15 of the round the subkey belongs to (sequence position, not key number)
- done  output  1  high after 16 subkeys have been issued since the last load
- overrun  output  1  sticky: advance received after done or before any load
- parity_err  output  1  sticky: load saw a key byte with even parity (PARITY_CHECK=1 only)

Behaviour:
- Reset (synchronous, active-high) wins over all inputs in the same cycle. It clears:
  - C, D, mode, count, subkey, subkey_round
  - subkey_valid, done, overrun, parity_err
  - the internal loaded flag
- A reset applied mid-sequence aborts the sequence; the next subkey requires a new load.

Load:
- C <= PC-1 bits 1..28; D <= PC-1 bits 29..56.
- mode <= decrypt; count <= 0; done <= 0; loaded <= 1.
- subkey_valid is 0 in the load cycle.
- overrun and parity_err are not cleared by load. parity_err is OR-set by load when the check fails.

Advance (accepted when loaded=1 and done=0), with n = count:
- Encrypt: C,D each rotate left by L[n].
  - L = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1
- Decrypt: C,D each rotate right by R[n].
  - R = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1
- The rotation is 28-bit with wrap-around, and the total shift over 16 rounds is 28.
- Encrypt therefore ends with C/D back at their loaded values. Decrypt's first subkey uses the unrotated C0/D0, which equals C16/D16.
- Next cycle: subkey <= PC-2 of the post-rotation C/D; subkey_round <= n; subkey_valid <= 1; count <= n+1.
- Latency is 1 cycle from advance to subkey_valid.
- Back-to-back advance strobes are legal and give one subkey per cycle.
- When the accepted advance has n = 15, done <= 1 in the same cycle subkey_valid is asserted for round 15.

Boundary conditions:
- Advance with done=1 or loaded=0: ignored (no rotation, no subkey_valid), overrun <= 1.
- Load and advance in the same cycle: load wins and advance is dropped. overrun is not set.
- Load during a sequence: restarts at count 0 with the new key and mode.
- key and decrypt are don't-care except in a load cycle.
- subkey holds its last value when subkey_valid=0.

Test Plan:
- Encrypt order: load key=133457799BBCDFF1 with decrypt=0, then 16 consecutive advances.
  - Internal C0=F0CCAAF, D0=556678F.
  - Round 0 subkey=1B02EFFC7072; round 1 = 79AED9DBC9E5; round 15 = CB3D8B0E17F5.
  - done rises with round 15; C/D end equal to C0/D0.
- Decrypt order: same key with decrypt=1, 16 advances.
  - Round 0 subkey=CB3D8B0E17F5; round 15 = 1B02EFFC7072.
  - The full sequence is the exact reverse of the encrypt run.
- Gaps and overrun: advances separated by 0–3 idle cycles give identical subkeys to the back-to-back run.
  - A 17th advance produces no subkey_valid and sets overrun=1.
  - overrun stays 1 after a following load.
- Collisions and restart:
  - load+advance in the same cycle gives no subkey_valid; the next advance outputs round 0.
  - A load after 5 rounds restarts at round 0 with the new key.
  - A reset after 7 rounds clears all outputs to 0, and a subsequent advance sets overrun.
- PARITY_CHECK=1:
  - Loading 133457799BBCDFF1 leaves parity_err=0.
  - Loading 0000000000000000 sets parity_err=1, and it stays set until reset.
